// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter owner sequencing fetch through IDLE/RUN/HALT with branch, stall and halt control
module pc_sequencer #(
    parameter int                  PC_WIDTH  = 8,
    parameter int                  CNT_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [PC_WIDTH-1:0]  startadd_i,
    input  logic                 halt_i,
    input  logic                 stall_i,
    input  logic                 branchf_i,
    input  logic                 branchb_i,
    input  logic [PC_WIDTH-1:0]  target_i,
    output logic [PC_WIDTH-1:0]  pc_o,
    output logic                 fetch_en_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] icount_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;
    logic [1:0]           state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d, pc_base;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d, run, adv, both;
    always_comb begin
        run        = state_q == RUN;
        adv        = run && !halt_i && !stall_i;
        both       = branchf_i && branchb_i;
        // A conflicting branch falls back to a plain increment
        pc_base    = both ? pc_q : branchf_i ? pc_q + target_i : branchb_i ? pc_q - target_i : pc_q;
        pc_d       = start_i ? startadd_i : adv ? pc_base + PC_WIDTH'(1) : pc_q;
        cnt_d      = start_i ? '0 : (adv && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        err_d      = start_i ? 1'b0 : err_q | (adv & both);
        state_d    = start_i ? RUN : (run && halt_i) ? HALT : state_q;
        fetch_en_o = run && !stall_i;
        done_o     = state_q == HALT;
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    assign pc_o     = pc_q;
    assign icount_o = cnt_q;
    assign err_o    = err_q;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Sequential controller that owns the program counter register and drives the next-PC rules of the `pc` block each cycle. The next-PC rules are start address, forward branch, backward branch and increment. It sits between decode and instruction memory. It sequences fetch through IDLE/RUN/HALT, honours stall and halt requests, counts executed instructions and flags conflicting branch requests.

Parameters:
PC_WIDTH, 8, program counter width; all PC arithmetic is modulo 2^PC_WIDTH
CNT_WIDTH, 16, executed-instruction counter width
RESET_PC, 0, PC value loaded on reset

Ports:
clk_i  input  1  clock; all state changes on rising edge
reset_i  input  1  synchronous, active-high reset
start_i  input  1  load startadd_i and enter RUN; accepted in any state
startadd_i  input  PC_WIDTH  start address
halt_i  input  1  halt request from decode (RUN only)
stall_i  input  1  hold PC this cycle (RUN only)
branchf_i  input  1  forward branch request
branchb_i  input  1  backward branch request
target_i  input  PC_WIDTH  branch offset, unsigned
pc_o  output  PC_WIDTH  current PC (registered)
fetch_en_o  output  1  high while state==RUN and stall_i==0
done_o  output  1  high while state==HALT
err_o  output  1  sticky: branchf_i and branchb_i seen together
icount_o  output  CNT_WIDTH  PC advances since last start (registered)

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset values: state=IDLE, pc_o=RESET_PC, icount_o=0, err_o=0, done_o=0, fetch_en_o=0.
- Priority each edge: reset_i > start_i > halt_i > stall_i > branch > increment.
- States:
  - IDLE: pc_o and icount_o hold. Transition on start_i to RUN.
  - RUN: advances PC. Transition on halt_i to HALT.
  - HALT: pc_o and icount_o hold. Transition on start_i to RUN.
- start_i, in any state: pc_o<=startadd_i, icount_o<=0, err_o<=0, state<=RUN. It takes effect on the next edge; this is not a PC advance.
- RUN, halt_i=1: state<=HALT, pc_o holds, icount_o holds. Branch and stall inputs are ignored that cycle.
- RUN, stall_i=1 (no halt): pc_o and icount_o hold; fetch_en_o=0.
- RUN, advance (no start/halt/stall): icount_o<=icount_o+1, saturating at all-ones. Next PC is:
  - branchf_i only: pc_o + target_i + 1
  - branchb_i only: pc_o - target_i + 1
  - neither: pc_o + 1
  - both: pc_o + 1, and err_o<=1
- All PC sums wrap modulo 2^PC_WIDTH, with no overflow flag.
- In IDLE and HALT, branch, stall and halt inputs are ignored and err_o is not set.
- err_o is cleared only by reset_i or start_i.
- Latency: a request sampled at edge N is visible on pc_o after edge N; one cycle per step.
- fetch_en_o and done_o are decoded from the state register (plus stall_i for fetch_en_o). No other combinational input-to-output paths.
- Reset mid-RUN overrides every simultaneous request.
- start_i together with halt_i: start wins, state=RUN.

Test Plan:
- Reset: assert reset_i 2 cycles -> pc_o=0x00, state IDLE, fetch_en_o=0, done_o=0, err_o=0, icount_o=0. Hold 5 idle cycles -> pc_o stays 0x00.
- Start and increment: start_i with startadd_i=0x10, then 3 free cycles -> pc_o 0x10,0x11,0x12,0x13; icount_o=3; fetch_en_o=1.
- Branch arithmetic: start at 0x00; branchf_i with target 0x29 -> 0x2A; then branchb_i with target 0x05 -> 0x26; then plain cycle -> 0x27.
- Wrap-around:
  - pc 0xFE, branchf_i with target 0x05 -> 0x04
  - pc 0xFF, plain increment -> 0x00
  - pc 0x02, branchb_i with target 0x05 -> 0xFE
- Stall/halt:
  - stall_i 2 cycles at pc 0x30 -> pc_o=0x30, icount_o unchanged, fetch_en_o=0
  - halt_i -> done_o=1, pc_o holds 0x30 for 4 cycles despite branchf_i
  - start_i with 0x40 -> RUN, pc_o=0x40, icount_o=0, done_o=0
- Conflict and priority:
  - branchf_i=branchb_i=1 at pc 0x50 -> pc_o=0x51, err_o=1, err_o stays set for later cycles
  - start_i -> err_o=0
  - reset_i and start_i in the same cycle -> IDLE, pc_o=0x00
